// File: rtl/fibonacci_index.sv
// Fibonacci classifier: finds the smallest k with F(k) >= value, one comparison per clock.
// Reports whether value == F(k) and the index k. Works as a checker for fibonacci_gen.
// Optional macro FIB_CEIL_EN adds the fib_ceil output, which carries F(index).
module fibonacci_index #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             is_fib,
  output logic [IDX_W-1:0] index
`ifdef FIB_CEIL_EN
  ,
  output logic [WIDTH:0]   fib_ceil
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, b_q;
  logic [WIDTH-1:0] value_q;
  logic [IDX_W-1:0] k_q;
  logic             is_fib_q;
  logic [IDX_W-1:0] index_q;
`ifdef FIB_CEIL_EN
  logic [WIDTH:0]   fib_ceil_q;
`endif

  logic           accept;
  logic           found;
  logic [WIDTH:0] value_ext;

  // A new search is taken only when idle or in the single done cycle.
  assign accept    = start && ((state_q == StIdle) || (state_q == StDone));
  assign value_ext = {1'b0, value_q};
  // a is one bit wider than value, so a >= value is reached before a can wrap.
  assign found     = (state_q == StRun) && (a_q >= value_ext);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = accept ? StRun : StIdle;
      StRun:   state_d = found ? StDone : StRun;
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from state; busy and done are mutually exclusive.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Search datapath and result registers; results change only when a search ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= {{WIDTH{1'b0}}, 1'b1};
      k_q        <= '0;
      value_q    <= '0;
      is_fib_q   <= 1'b0;
      index_q    <= '0;
`ifdef FIB_CEIL_EN
      fib_ceil_q <= '0;
`endif
    end else if (accept) begin
      value_q <= value;
      a_q     <= '0;
      b_q     <= {{WIDTH{1'b0}}, 1'b1};
      k_q     <= '0;
    end else if (state_q == StRun) begin
      if (found) begin
        is_fib_q   <= (a_q == value_ext);
        index_q    <= k_q;
`ifdef FIB_CEIL_EN
        fib_ceil_q <= a_q;
`endif
      end else begin
        a_q <= b_q;
        b_q <= a_q + b_q;
        k_q <= k_q + IDX_W'(1);
      end
    end
  end

  assign is_fib   = is_fib_q;
  assign index    = index_q;
`ifdef FIB_CEIL_EN
  assign fib_ceil = fib_ceil_q;
`endif

endmodule

// File: tb/tb_fibonacci_index.sv
// Directed self-checking bench for fibonacci_index (WIDTH=8, IDX_W=8).
// Results and latencies are hand-computed from F(0)=0, F(1)=1, ...
module tb_fibonacci_index;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] value;
  logic       busy;
  logic       done;
  logic       is_fib;
  logic [7:0] index;
`ifdef FIB_CEIL_EN
  logic [8:0] fib_ceil;
`endif

  int passed = 0;
  int total  = 0;

  fibonacci_index #(
    .WIDTH (8),
    .IDX_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .is_fib   (is_fib),
    .index    (index)
`ifdef FIB_CEIL_EN
    ,
    .fib_ceil (fib_ceil)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (on negedges) until done, counting edges since the start-sampling edge.
  task automatic wait_done(input int e0, output int edges, output int busy_cnt,
                           output bit overlap);
    edges    = e0;
    busy_cnt = 0;
    overlap  = 1'b0;
    while (!done && edges < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      edges++;
    end
    if (done && busy) overlap = 1'b1;
  endtask

  // Present start/value for one sampling edge, then wait for the result.
  task automatic run_wait(input logic [7:0] v, output int edges, output int busy_cnt,
                          output bit overlap);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, edges, busy_cnt, overlap);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    value = 8'd0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
    total++; if (is_fib !== 1'b0) $display("FAIL rst_isfib: got %b want 0", is_fib); else passed++;
    total++; if (index !== 8'd0) $display("FAIL rst_index: got %0d want 0", index); else passed++;
`ifdef FIB_CEIL_EN
    total++; if (fib_ceil !== 9'd0) $display("FAIL rst_ceil: got %0d want 0", fib_ceil);
    else passed++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero;
    int e, bc;
    bit ov;
    run_wait(8'd0, e, bc, ov);
    total++; if (e !== 1) $display("FAIL zero_lat: got %0d want 1", e); else passed++;
    total++; if (is_fib !== 1'b1) $display("FAIL zero_isfib: got %b want 1", is_fib); else passed++;
    total++; if (index !== 8'd0) $display("FAIL zero_index: got %0d want 0", index); else passed++;
`ifdef FIB_CEIL_EN
    total++; if (fib_ceil !== 9'd0) $display("FAIL zero_ceil: got %0d want 0", fib_ceil);
    else passed++;
`endif
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL zero_pulse: got %b want 0", done); else passed++;
  endtask

  task automatic test_thirteen;
    int e, bc;
    bit ov;
    run_wait(8'd13, e, bc, ov);
    total++; if (e !== 8) $display("FAIL f13_lat: got %0d want 8", e); else passed++;
    total++; if (bc !== 8) $display("FAIL f13_busy: got %0d want 8", bc); else passed++;
    total++; if (ov !== 1'b0) $display("FAIL f13_overlap: got %b want 0", ov); else passed++;
    total++; if (is_fib !== 1'b1) $display("FAIL f13_isfib: got %b want 1", is_fib); else passed++;
    total++; if (index !== 8'd7) $display("FAIL f13_index: got %0d want 7", index); else passed++;
`ifdef FIB_CEIL_EN
    total++; if (fib_ceil !== 9'd13) $display("FAIL f13_ceil: got %0d want 13", fib_ceil);
    else passed++;
`endif
    @(negedge clk);
  endtask

  task automatic test_fib_values;
    int e, bc;
    bit ov;
    run_wait(8'd1, e, bc, ov);
    total++; if (e !== 2) $display("FAIL one_lat: got %0d want 2", e); else passed++;
    total++; if (is_fib !== 1'b1) $display("FAIL one_isfib: got %b want 1", is_fib); else passed++;
    total++; if (index !== 8'd1) $display("FAIL one_index: got %0d want 1", index); else passed++;
`ifdef FIB_CEIL_EN
    total++; if (fib_ceil !== 9'd1) $display("FAIL one_ceil: got %0d want 1", fib_ceil);
    else passed++;
`endif
    @(negedge clk);
    run_wait(8'd233, e, bc, ov);
    total++; if (e !== 14) $display("FAIL f233_lat: got %0d want 14", e); else passed++;
    total++; if (is_fib !== 1'b1) $display("FAIL f233_isfib: got %b want 1", is_fib); else passed++;
    total++; if (index !== 8'd13) $display("FAIL f233_index: got %0d want 13", index); else passed++;
    @(negedge clk);
  endtask

  task automatic test_non_fib;
    int e, bc;
    bit ov;
    run_wait(8'd100, e, bc, ov);
    total++; if (is_fib !== 1'b0) $display("FAIL n100_isfib: got %b want 0", is_fib); else passed++;
    total++; if (index !== 8'd12) $display("FAIL n100_index: got %0d want 12", index); else passed++;
`ifdef FIB_CEIL_EN
    total++; if (fib_ceil !== 9'd144) $display("FAIL n100_ceil: got %0d want 144", fib_ceil);
    else passed++;
`endif
    @(negedge clk);
    run_wait(8'd255, e, bc, ov);
    total++; if (e !== 15) $display("FAIL n255_lat: got %0d want 15", e); else passed++;
    total++; if (is_fib !== 1'b0) $display("FAIL n255_isfib: got %b want 0", is_fib); else passed++;
    total++; if (index !== 8'd14) $display("FAIL n255_index: got %0d want 14", index); else passed++;
`ifdef FIB_CEIL_EN
    total++; if (fib_ceil !== 9'd377) $display("FAIL n255_ceil: got %0d want 377", fib_ceil);
    else passed++;
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int e, bc;
    bit ov;
    start = 1'b1;
    value = 8'd55;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    // Edge count is now 3; this start arrives mid-run and must be ignored.
    start = 1'b1;
    value = 8'd2;
    @(negedge clk);
    start = 1'b0;
    value = 8'd0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else passed++;
    total++; if (index !== 8'd14) $display("FAIL b2b_hold: got %0d want 14", index); else passed++;
    wait_done(4, e, bc, ov);
    total++; if (e !== 11) $display("FAIL f55_lat: got %0d want 11", e); else passed++;
    total++; if (is_fib !== 1'b1) $display("FAIL f55_isfib: got %b want 1", is_fib); else passed++;
    total++; if (index !== 8'd10) $display("FAIL f55_index: got %0d want 10", index); else passed++;
    // Start during the done cycle is accepted.
    run_wait(8'd3, e, bc, ov);
    total++; if (e !== 5) $display("FAIL f3_lat: got %0d want 5", e); else passed++;
    total++; if (is_fib !== 1'b1) $display("FAIL f3_isfib: got %b want 1", is_fib); else passed++;
    total++; if (index !== 8'd4) $display("FAIL f3_index: got %0d want 4", index); else passed++;
`ifdef FIB_CEIL_EN
    total++; if (fib_ceil !== 9'd3) $display("FAIL f3_ceil: got %0d want 3", fib_ceil);
    else passed++;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int e, bc, done_seen;
    bit ov;
    start = 1'b1;
    value = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done); else passed++;
    total++; if (is_fib !== 1'b0) $display("FAIL abort_isfib: got %b want 0", is_fib); else passed++;
    total++; if (index !== 8'd0) $display("FAIL abort_index: got %0d want 0", index); else passed++;
`ifdef FIB_CEIL_EN
    total++; if (fib_ceil !== 9'd0) $display("FAIL abort_ceil: got %0d want 0", fib_ceil);
    else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    total++; if (done_seen !== 0) $display("FAIL abort_quiet: got %0d want 0", done_seen);
    else passed++;
    run_wait(8'd8, e, bc, ov);
    total++; if (is_fib !== 1'b1) $display("FAIL f8_isfib: got %b want 1", is_fib); else passed++;
    total++; if (index !== 8'd6) $display("FAIL f8_index: got %0d want 6", index); else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_thirteen();
    test_fib_values();
    test_non_fib();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
